// File: rtl/dsp_pipe_pkg.sv
// dsp_pipe_pkg
//   Shared constants and helpers for the DSP register pipelines.
//   MAX_PIPE_DEPTH : deepest legal register pipe
//   MAX_DATA_WIDTH : widest legal data word
//   clog2()        : constant ceil(log2(n)), 0 for n <= 1
//   cnt_width()    : occupancy counter width for a given depth, at least 1
package dsp_pipe_pkg;

    localparam int MAX_PIPE_DEPTH = 8;
    localparam int MAX_DATA_WIDTH = 64;

    function automatic int clog2(input int unsigned n);
        int unsigned v;
        int          r;
        v = 1;
        r = 0;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int cnt_width(input int depth);
        int w;
        w = clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/elastic_reg_pipe_stage.sv
// pipe_stage
//   One elastic register stage: a valid bit plus a data register.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset, clears valid and data
//   flush      : synchronous clear of the valid bit, data kept
//   up_valid_i : word offered by the stage behind
//   up_data_i  : data of that word
//   dn_ready_i : stage ahead (or downstream) can take this stage's word
//   ready_o    : this stage can take a word at the next edge
//   valid_o    : this stage holds a word
//   data_o     : the held word
module pipe_stage
    import dsp_pipe_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic             dn_ready_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // Ready ripples combinationally: empty, or the word here leaves this edge.
    assign ready_o = !valid_q || dn_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (ready_o) begin
            valid_d = up_valid_i;
            // Bubbles do not overwrite the data register, so the head keeps
            // its reset value of zero until a real word reaches it.
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/elastic_reg_pipe.sv
// elastic_reg_pipe
//   DEPTH-stage valid/ready register pipeline with full throughput and a
//   combinational ready chain; DEPTH = 0 is a pure wire bypass.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset, discards all words
//   flush     : synchronous discard of all held words (ignored at DEPTH 0)
//   in_valid  : upstream word present
//   in_ready  : word is accepted this cycle
//   in_data   : upstream word
//   out_valid : out_data holds a valid word
//   out_ready : downstream accepts this cycle
//   out_data  : word at the pipe head
//   occupancy : number of valid stages
module elastic_reg_pipe
    import dsp_pipe_pkg::*;
#(
    parameter  int WIDTH = 18,
    parameter  int DEPTH = 2,
    localparam int CNTW  = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  occupancy
);

    if (DEPTH < 0 || DEPTH > MAX_PIPE_DEPTH) begin : g_bad_depth
        $error("elastic_reg_pipe: DEPTH %0d outside 0..%0d", DEPTH, MAX_PIPE_DEPTH);
    end

    if (WIDTH < 1 || WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("elastic_reg_pipe: WIDTH %0d outside 1..%0d", WIDTH, MAX_DATA_WIDTH);
    end

    if (DEPTH == 0) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = ^{clk, rst, flush};

        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign in_ready  = out_ready;
        assign occupancy = '0;
    end else begin : g_pipe
        logic [DEPTH-1:0] v;
        logic [WIDTH-1:0] d [DEPTH];
        logic [DEPTH:0]   r;

        assign r[DEPTH] = out_ready;

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            logic             up_v;
            logic [WIDTH-1:0] up_d;

            if (k == 0) begin : g_head
                assign up_v = in_valid && in_ready;
                assign up_d = in_data;
            end else begin : g_body
                assign up_v = v[k-1];
                assign up_d = d[k-1];
            end

            pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .flush      (flush),
                .up_valid_i (up_v),
                .up_data_i  (up_d),
                .dn_ready_i (r[k+1]),
                .ready_o    (r[k]),
                .valid_o    (v[k]),
                .data_o     (d[k])
            );
        end

        assign in_ready  = r[0] && !flush;
        assign out_valid = v[DEPTH-1];
        assign out_data  = d[DEPTH-1];
        assign occupancy = CNTW'($countones(v));
    end

endmodule

// File: tb/tb_elastic_reg_pipe.sv
module tb_elastic_reg_pipe;

    localparam int NI = 6;
    localparam int W  = 18;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic [NI-1:0] ov;
    logic [NI-1:0] ir;
    logic [W-1:0]  od [NI];
    logic [3:0]    oc [NI];
    logic [1:0]    oc0, oc1;
    logic [2:0]    oc2;
    logic          oc3, oc4;
    logic [3:0]    oc5;

    assign oc[0] = {2'b00, oc0};
    assign oc[1] = {2'b00, oc1};
    assign oc[2] = {1'b0, oc2};
    assign oc[3] = {3'b000, oc3};
    assign oc[4] = {3'b000, oc4};
    assign oc[5] = oc5;

    always #5 clk = ~clk;

    elastic_reg_pipe #(.WIDTH(W), .DEPTH(3)) u_d3 (.clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .occupancy(oc0));
    elastic_reg_pipe #(.WIDTH(W), .DEPTH(2)) u_d2 (.clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .occupancy(oc1));
    elastic_reg_pipe #(.WIDTH(W), .DEPTH(4)) u_d4 (.clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2]), .occupancy(oc2));
    elastic_reg_pipe #(.WIDTH(W), .DEPTH(0)) u_d0 (.clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data), .out_valid(ov[3]),
        .out_ready(out_ready), .out_data(od[3]), .occupancy(oc3));
    elastic_reg_pipe #(.WIDTH(W), .DEPTH(1)) u_d1 (.clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[4]), .in_data(in_data), .out_valid(ov[4]),
        .out_ready(out_ready), .out_data(od[4]), .occupancy(oc4));
    elastic_reg_pipe #(.WIDTH(W), .DEPTH(8)) u_d8 (.clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[5]), .in_data(in_data), .out_valid(ov[5]),
        .out_ready(out_ready), .out_data(od[5]), .occupancy(oc5));

    function automatic int dep(input int i);
        case (i)
            0: return 3;
            1: return 2;
            2: return 4;
            3: return 0;
            4: return 1;
            default: return 8;
        endcase
    endfunction

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s u%0d t=%0t got=%h want=%h", nm, idx, $time, act, exp);
        end
    endtask

    // Model: each instance is a FIFO of accepted words. A word accepted in
    // cycle a reaches the head no earlier than cycle a+DEPTH, and no earlier
    // than the cycle after the word in front of it left.
    logic [W-1:0] mdat [NI][16];
    int           macc [NI][16];
    int           mhd  [NI];
    int           mcnt [NI];
    int           hs   [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            mhd[i] = 0; mcnt[i] = 0; hs[i] = 0;
        end
    end

    always @(negedge clk) begin
        int           D, n, vis, slot;
        logic         ev, er;
        logic [W-1:0] ed;
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            D = dep(i);
            if (!rst) begin
                mcnt[i] = 0;
                mhd[i]  = 0;
            end
            if (D == 0) begin
                ev = in_valid; ed = in_data; er = out_ready; n = 0;
            end else begin
                n   = mcnt[i];
                vis = macc[i][mhd[i]] + D;
                if (hs[i] > vis) vis = hs[i];
                ev  = (n > 0) && (vis <= cyc);
                ed  = mdat[i][mhd[i]];
                er  = !flush && ((n < D) || out_ready);
            end
            chk("out_valid", i, 32'(ov[i]), 32'(ev));
            chk("in_ready", i, 32'(ir[i]), 32'(er));
            chk("occupancy", i, 32'(oc[i]), n);
            if (ev) chk("out_data", i, 32'(od[i]), 32'(ed));
            if (rst && D > 0) begin
                if (flush) begin
                    mcnt[i] = 0;
                end else begin
                    if (ev && out_ready) begin
                        mhd[i]  = (mhd[i] + 1) % 16;
                        mcnt[i] = mcnt[i] - 1;
                        hs[i]   = cyc + 1;
                    end
                    if (in_valid && er) begin
                        slot = (mhd[i] + mcnt[i]) % 16;
                        mdat[i][slot] = in_data;
                        macc[i][slot] = cyc;
                        mcnt[i] = mcnt[i] + 1;
                    end
                end
            end
        end
    end

    logic         acc0;
    logic [W-1:0] em [32];
    int           ne = 0;

    // Apply one cycle of inputs; note whether the DEPTH=3 pipe accepted and
    // log its emissions. Returns 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [W-1:0] dat, input logic ordy,
                         input logic fl);
        in_valid = v; in_data = dat; out_ready = ordy; flush = fl;
        @(negedge clk);
        #1;
        acc0 = v && ir[0];
        if (ov[0] && ordy && ne < 32) begin
            em[ne] = od[0];
            ne = ne + 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        in_valid = 1'b1; in_data = 18'h2AAAA; out_ready = 1'b0; flush = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", 0, 32'(ov[0]), 0);
        chk("rst_data", 0, 32'(od[0]), 0);
        chk("rst_occ", 0, 32'(oc[0]), 0);
        chk("rst_ready", 0, 32'(ir[0]), 1);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rel_ready", 0, 32'(ir[0]), 1);
        chk("rel_valid", 0, 32'(ov[0]), 0);

        // streaming, DEPTH 3
        drive(1, 18'd1, 1, 0);
        drive(1, 18'd2, 1, 0);
        chk("str_v0", 0, 32'(ov[0]), 0);
        drive(1, 18'd3, 1, 0);
        chk("str_v1", 0, 32'(ov[0]), 1);
        chk("str_w1", 0, 32'(od[0]), 1);
        drive(1, 18'd4, 1, 0);
        chk("str_w2", 0, 32'(od[0]), 2);
        drive(0, '0, 1, 0);
        chk("str_w3", 0, 32'(od[0]), 3);
        drive(0, '0, 1, 0);
        chk("str_w4", 0, 32'(od[0]), 4);
        drive(0, '0, 1, 0);
        chk("str_end", 0, 32'(ov[0]), 0);

        // backpressure, DEPTH 3
        repeat (10) drive(0, '0, 1, 0);
        k = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1, W'(32'h101 + k), 0, 0);
            if (acc0) k = k + 1;
        end
        chk("bp_acc", 0, k, 3);
        chk("bp_ready", 0, 32'(ir[0]), 0);
        chk("bp_occ", 0, 32'(oc[0]), 3);
        chk("bp_head", 0, 32'(od[0]), 32'h101);
        chk("bp_valid", 0, 32'(ov[0]), 1);
        ne = 0;
        for (int c = 0; c < 20; c++) begin
            if (k < 5) begin
                drive(1, W'(32'h101 + k), 1, 0);
                if (acc0) k = k + 1;
            end else begin
                drive(0, '0, 1, 0);
            end
        end
        chk("bp_count", 0, ne, 5);
        for (int j = 0; j < 5; j++) chk("bp_order", 0, 32'(em[j]), 32'h101 + j);

        // full pass-through, DEPTH 2
        repeat (10) drive(0, '0, 1, 0);
        for (int c = 0; c < 4; c++) drive(1, W'(32'h200 + c), 0, 0);
        chk("fp_fill", 1, 32'(oc[1]), 2);
        chk("fp_full", 1, 32'(ir[1]), 0);
        for (int c = 0; c < 4; c++) begin
            drive(1, W'(32'h210 + c), 1, 0);
            chk("fp_occ", 1, 32'(oc[1]), 2);
            chk("fp_rdy", 1, 32'(ir[1]), 1);
            chk("fp_head", 1, 32'(od[1]), (c == 0) ? 32'h201 : 32'h210 + c - 1);
        end

        // flush, DEPTH 4
        repeat (10) drive(0, '0, 1, 0);
        for (int c = 0; c < 3; c++) drive(1, W'(32'h300 + c), 0, 0);
        chk("fl_pre", 2, 32'(oc[2]), 3);
        in_valid = 1'b1; in_data = 18'h3BAD; flush = 1'b1; out_ready = 1'b0;
        #1;
        chk("fl_rdy", 2, 32'(ir[2]), 0);
        drive(1, 18'h3BAD, 0, 1);
        chk("fl_acc", 0, 32'(acc0), 0);
        chk("fl_occ", 2, 32'(oc[2]), 0);
        chk("fl_valid", 2, 32'(ov[2]), 0);
        repeat (8) drive(0, '0, 1, 0);
        chk("fl_quiet", 2, 32'(ov[2]), 0);
        drive(1, 18'h377, 1, 0);
        repeat (10) drive(0, '0, 1, 0);

        // bypass, DEPTH 0
        in_valid = 1'b1; in_data = 18'h12345; out_ready = 1'b0; flush = 1'b0;
        #1;
        chk("bp0_data", 3, 32'(od[3]), 32'h12345);
        chk("bp0_valid", 3, 32'(ov[3]), 1);
        chk("bp0_rdy0", 3, 32'(ir[3]), 0);
        out_ready = 1'b1;
        #1;
        chk("bp0_rdy1", 3, 32'(ir[3]), 1);
        flush = 1'b1;
        #1;
        chk("bp0_flush", 3, 32'(ir[3]), 1);
        drive(1, 18'h12345, 0, 0);
        drive(1, 18'h12345, 1, 0);
        repeat (10) drive(0, '0, 1, 0);

        // asynchronous reset with words in flight
        for (int c = 0; c < 3; c++) drive(1, W'(32'h400 + c), 0, 0);
        chk("ar_pre", 0, 32'(oc[0]), 3);
        #2 rst = 1'b0;
        #1;
        chk("ar_occ", 0, 32'(oc[0]), 0);
        chk("ar_valid", 0, 32'(ov[0]), 0);
        chk("ar_data", 0, 32'(od[0]), 0);
        chk("ar_occ8", 5, 32'(oc[5]), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // mixed handshake pattern with one flush
        for (int i = 0; i < 60; i++)
            drive((i % 3) != 0, W'(32'h500 + i), (i % 5) < 3, i == 23);
        repeat (12) drive(0, '0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
